// File: rtl/maria_bus_pkg.sv
// ============================================================================
// maria_bus_pkg
// Shared region/state encodings and address-map constants for Maria DMA reads.
// Revision: 1.0
// ============================================================================
`default_nettype none

package maria_bus_pkg;

    // Region encoding doubles as the external memory select code.
    typedef enum logic [1:0] {
        REGION_RAM      = 2'd0,
        REGION_BIOS     = 2'd1,
        REGION_CART     = 2'd2,
        REGION_UNMAPPED = 2'd3
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] RAM_LO  = 16'h1800;
    localparam logic [15:0] RAM_HI  = 16'h27FF;
    localparam logic [15:0] BIOS_LO = 16'hF000;
    localparam logic [15:0] CART_LO = 16'h4000;

endpackage

`default_nettype wire

// File: rtl/dma_addr_decode.sv
// ============================================================================
// dma_addr_decode
// Combinational memory-map decode of a 16-bit bus address into a region.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_addr_decode
    import maria_bus_pkg::*;
(
    input  logic [15:0] addr,
    input  logic        bios_en,
    output region_t     region
);

    // Priority order matters: BIOS overlays the top of cartridge space.
    always_comb begin
        region = REGION_UNMAPPED;
        if (addr >= RAM_LO && addr <= RAM_HI) begin
            region = REGION_RAM;
        end else if (bios_en && addr >= BIOS_LO) begin
            region = REGION_BIOS;
        end else if (addr >= CART_LO) begin
            region = REGION_CART;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_mem_responder.sv
// ============================================================================
// dma_mem_responder
// Serves one-byte DMA reads from RAM/BIOS/cart with a one-entry hit cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_mem_responder
    import maria_bus_pkg::*;
#(
    parameter int          TIMEOUT       = 15,
    parameter logic [7:0]  UNMAPPED_DATA = 8'h00,
    parameter logic [7:0]  TIMEOUT_DATA  = 8'hFF
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    output logic        dma_ack,
    output logic [7:0]  dma_data,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err,
    input  logic        bios_en,
    input  logic        cpu_write,
    output logic        mem_req,
    output logic [1:0]  mem_sel,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t       state;
    state_t       next_state;
    region_t      req_region;
    logic         cache_valid;
    logic [15:0]  cache_addr;
    region_t      cache_region;
    logic [7:0]   cache_data;
    logic [7:0]   pend_data;
    logic         pend_timeout;
    logic         inval_pending;
    logic [CNT_W-1:0] tmo_cnt;

    logic cache_hit;
    logic accept;
    logic start_fetch;
    logic fill;
    logic abort;
    logic respond;

    dma_addr_decode u_decode (
        .addr    (dma_addr),
        .bios_en (bios_en),
        .region  (req_region)
    );

    // Region is part of the tag so a bios_en flip cannot return a stale BIOS byte.
    assign cache_hit = cache_valid && (cache_addr == dma_addr) &&
                       (cache_region == req_region) && !cpu_write;
    assign busy = (state != ST_IDLE);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        start_fetch = 1'b0;
        fill        = 1'b0;
        abort       = 1'b0;
        respond     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dma_req) begin
                    accept = 1'b1;
                    if (req_region == REGION_UNMAPPED || cache_hit) begin
                        next_state = ST_RESP;
                    end else begin
                        start_fetch = 1'b1;
                        next_state  = ST_FETCH;
                    end
                end
            end
            ST_RESP: begin
                respond    = 1'b1;
                next_state = ST_IDLE;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    fill       = 1'b1;
                    next_state = ST_DONE;
                end else if (tmo_cnt == CNT_W'(1)) begin
                    abort      = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                respond    = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            dma_ack       <= 1'b0;
            dma_data      <= 8'h00;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
            mem_req       <= 1'b0;
            mem_sel       <= 2'd0;
            mem_addr      <= 16'h0000;
            cache_valid   <= 1'b0;
            cache_addr    <= 16'h0000;
            cache_region  <= REGION_RAM;
            cache_data    <= 8'h00;
            pend_data     <= 8'h00;
            pend_timeout  <= 1'b0;
            inval_pending <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            dma_ack     <= respond;
            timeout_err <= respond && (state == ST_DONE) && pend_timeout;
            if (respond) begin
                dma_data <= pend_data;
            end
            if (dma_req && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            if (cpu_write) begin
                cache_valid <= 1'b0;
            end
            if (accept) begin
                pend_data    <= (req_region == REGION_UNMAPPED) ? UNMAPPED_DATA : cache_data;
                pend_timeout <= 1'b0;
            end
            if (start_fetch) begin
                mem_req       <= 1'b1;
                mem_sel       <= req_region;
                mem_addr      <= dma_addr;
                tmo_cnt       <= CNT_W'(TIMEOUT);
                inval_pending <= 1'b0;
            end
            if (state == ST_FETCH) begin
                if (cpu_write) begin
                    inval_pending <= 1'b1;
                end
                if (fill) begin
                    // A write seen anywhere during the fetch leaves the fill invalid.
                    mem_req      <= 1'b0;
                    pend_data    <= mem_data;
                    cache_valid  <= !(inval_pending || cpu_write);
                    cache_addr   <= mem_addr;
                    cache_region <= region_t'(mem_sel);
                    cache_data   <= mem_data;
                end else if (abort) begin
                    mem_req      <= 1'b0;
                    pend_data    <= TIMEOUT_DATA;
                    pend_timeout <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dma_mem_responder.sv
// ============================================================================
// tb_dma_mem_responder
// Directed self-checking bench for dma_mem_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dma_mem_responder;

    logic        sysclk;
    logic        reset;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_ack;
    logic [7:0]  dma_data;
    logic        busy;
    logic        overrun;
    logic        timeout_err;
    logic        bios_en;
    logic        cpu_write;
    logic        mem_req;
    logic [1:0]  mem_sel;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;

    int n_assert = 0;
    int n_fail   = 0;
    int req_cycles;

    dma_mem_responder dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_ack     (dma_ack),
        .dma_data    (dma_data),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .bios_en     (bios_en),
        .cpu_write   (cpu_write),
        .mem_req     (mem_req),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] addr);
        dma_req  = 1'b1;
        dma_addr = addr;
        step();
        dma_req  = 1'b0;
    endtask

    // Called right after issue(): memory answers after 'wait_cycles' more cycles.
    task automatic serve(input int wait_cycles, input logic [7:0] data);
        for (int i = 0; i < wait_cycles; i++) step();
        mem_ack  = 1'b1;
        mem_data = data;
        step();
        mem_ack  = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; dma_req = 1'b0; dma_addr = 16'h0000; bios_en = 1'b1;
        cpu_write = 1'b0; mem_ack = 1'b0; mem_data = 8'h00;
        step();
        step();
        chk1 ("rst_dma_ack",  dma_ack, 1'b0);
        chk8 ("rst_dma_data", dma_data, 8'h00);
        chk1 ("rst_busy",     busy, 1'b0);
        chk1 ("rst_overrun",  overrun, 1'b0);
        chk1 ("rst_tmo",      timeout_err, 1'b0);
        chk1 ("rst_mem_req",  mem_req, 1'b0);
        chk8 ("rst_mem_sel",  {6'd0, mem_sel}, 8'h00);
        chk16("rst_mem_addr", mem_addr, 16'h0000);
        reset = 1'b0;
        step();

        // Unmapped read
        issue(16'h0400);
        chk1 ("unm_busy",    busy, 1'b1);
        chk1 ("unm_ack_n1",  dma_ack, 1'b0);
        chk1 ("unm_memreq",  mem_req, 1'b0);
        step();
        chk1 ("unm_ack_n2",  dma_ack, 1'b1);
        chk8 ("unm_data",    dma_data, 8'h00);
        chk1 ("unm_memreq2", mem_req, 1'b0);
        step();
        chk1 ("unm_ack_off", dma_ack, 1'b0);

        // RAM miss, memory answers 3 cycles after mem_req rises
        issue(16'h1900);
        chk1 ("ram_memreq",  mem_req, 1'b1);
        chk8 ("ram_sel",     {6'd0, mem_sel}, 8'h00);
        chk16("ram_addr",    mem_addr, 16'h1900);
        step(); step(); step();
        chk1 ("ram_hold",    mem_req, 1'b1);
        mem_ack = 1'b1; mem_data = 8'h5A;
        step();
        mem_ack = 1'b0;
        chk1 ("ram_drop",    mem_req, 1'b0);
        chk1 ("ram_ack_early", dma_ack, 1'b0);
        step();
        chk1 ("ram_ack",     dma_ack, 1'b1);
        chk8 ("ram_data",    dma_data, 8'h5A);
        step();
        chk8 ("ram_data_hold", dma_data, 8'h5A);

        // Stray mem_ack while idle must be ignored
        mem_ack = 1'b1; mem_data = 8'h77;
        step();
        mem_ack = 1'b0;
        chk1 ("stray_ack",   dma_ack, 1'b0);
        chk1 ("stray_busy",  busy, 1'b0);

        // RAM hit
        issue(16'h1900);
        chk1 ("hit_memreq",  mem_req, 1'b0);
        step();
        chk1 ("hit_ack",     dma_ack, 1'b1);
        chk8 ("hit_data",    dma_data, 8'h5A);
        step();

        // BIOS vs cart decode
        issue(16'hF123);
        chk8 ("bios_sel",    {6'd0, mem_sel}, 8'h01);
        chk16("bios_addr",   mem_addr, 16'hF123);
        serve(0, 8'h3C);
        chk8 ("bios_data",   dma_data, 8'h3C);
        step();
        bios_en = 1'b0;
        issue(16'hF123);
        chk1 ("cart_f_req",  mem_req, 1'b1);
        chk8 ("cart_f_sel",  {6'd0, mem_sel}, 8'h02);
        serve(1, 8'h4D);
        chk8 ("cart_f_data", dma_data, 8'h4D);
        step();
        issue(16'h4000);
        chk8 ("cart_sel",    {6'd0, mem_sel}, 8'h02);
        chk16("cart_addr",   mem_addr, 16'h4000);
        serve(2, 8'h11);
        chk8 ("cart_data",   dma_data, 8'h11);
        step();

        // Timeout: count mem_req-high cycles (bounded loop)
        issue(16'h8000);
        req_cycles = mem_req ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!mem_req) break;
            req_cycles++;
        end
        chk16("tmo_req_cycles", 16'(req_cycles), 16'd15);
        chk1 ("tmo_err_early", timeout_err, 1'b0);
        step();
        chk1 ("tmo_err",     timeout_err, 1'b1);
        chk1 ("tmo_ack",     dma_ack, 1'b1);
        chk8 ("tmo_data",    dma_data, 8'hFF);
        step();
        chk1 ("tmo_err_off", timeout_err, 1'b0);
        issue(16'h8000);
        chk1 ("tmo_refetch", mem_req, 1'b1);
        serve(0, 8'h99);
        chk8 ("refetch_data", dma_data, 8'h99);
        step();
        chk1 ("no_overrun_yet", overrun, 1'b0);

        // cpu_write coincident with a would-be hit forces a fetch
        dma_req = 1'b1; dma_addr = 16'h8000; cpu_write = 1'b1;
        step();
        dma_req = 1'b0; cpu_write = 1'b0;
        chk1 ("inv_fetch",   mem_req, 1'b1);
        chk1 ("inv_ovr0",    overrun, 1'b0);
        // Request during FETCH is dropped; a CPU write here poisons the fill
        dma_req = 1'b1; dma_addr = 16'h0400; cpu_write = 1'b1;
        step();
        dma_req = 1'b0; cpu_write = 1'b0;
        chk1 ("ovr_set",     overrun, 1'b1);
        chk16("ovr_addr",    mem_addr, 16'h8000);
        serve(0, 8'h22);
        chk1 ("inv_ack",     dma_ack, 1'b1);
        chk8 ("inv_data",    dma_data, 8'h22);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1 ("dropped_no_ack", dma_ack, 1'b0);
        end
        issue(16'h8000);
        chk1 ("poisoned_miss", mem_req, 1'b1);

        // Asynchronous reset mid-fetch
        #3;
        reset = 1'b1;
        #1;
        chk1 ("arst_memreq", mem_req, 1'b0);
        chk1 ("arst_busy",   busy, 1'b0);
        chk1 ("arst_ovr",    overrun, 1'b0);
        step();
        reset = 1'b0;
        mem_ack = 1'b1; mem_data = 8'hAB;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1 ("late_ack_ignored", dma_ack, 1'b0);
            step();
        end
        chk1 ("late_idle",   busy, 1'b0);
        issue(16'h1900);
        chk1 ("post_rst_miss", mem_req, 1'b1);
        serve(0, 8'h66);
        chk8 ("post_rst_data", dma_data, 8'h66);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
